spi_mem_bridge: RTL and testbench

SPI_MEM_BRIDGE -- requirements
Module: spi_mem_bridge

---
 rtl/spi_mem_pkg.sv | 22 ++
 rtl/spi_mem_array.sv | 28 ++
 rtl/spi_mem_bridge.sv | 143 ++++++++++++++
 tb/tb_spi_mem_bridge.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared FSM state encoding and 2-bit command codes for the SPI memory bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_TURN,
        S_RD_SHIFT,
        S_DONE
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_mem_array.sv
// Single-port synchronous word memory; out-of-range addresses ignore writes and read zero.
// Latency: 1 cycle from address to registered dout.
// Backpressure: none, accepts an access every cycle.
module spi_mem_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  in_range;

    assign in_range = ({1'b0, addr} < (ADDR_WIDTH+1)'(MEM_DEPTH));

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[addr] <= din;
        end
        dout <= in_range ? mem[addr] : '0;
    end

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI-style serial slave giving address/data access to a word memory (optional SPI_MEM_AUTO_INC_EN).
// Latency: write commits one edge after its last payload bit; read data starts on MISO 2 edges after the command.
// Backpressure: none; SS_n high aborts any frame in flight on the next edge.
module spi_mem_bridge
    import spi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO
);

    localparam int SH_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(SH_W + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    state_t                state, state_nxt;
    logic [SH_W-1:0]       shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [ADDR_WIDTH-1:0] shift_addr;
    logic                  wr_pend;
    logic                  abort;
    logic [DATA_WIDTH-1:0] mem_dout;

`ifdef SPI_MEM_AUTO_INC_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = ADDR_WIDTH'(MEM_DEPTH - 1);

    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_TOP) ? '0 : a + 1'b1;
    endfunction
`endif

    assign abort      = (state != S_IDLE) && SS_n;
    assign shift_addr = {shreg[ADDR_WIDTH-2:0], MOSI};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (!SS_n) state_nxt = S_CMD;
                S_CMD: begin
                    if (bit_cnt == CNT_W'(1)) begin
                        case ({shreg[0], MOSI})
                            CMD_WR_ADDR: state_nxt = S_WR_ADDR;
                            CMD_WR_DATA: state_nxt = S_WR_DATA;
                            CMD_RD_ADDR: state_nxt = S_RD_ADDR;
                            default:     state_nxt = S_RD_TURN;
                        endcase
                    end
                end
                S_WR_ADDR,
                S_RD_ADDR:  if (bit_cnt == ADDR_LAST) state_nxt = S_DONE;
                S_WR_DATA,
                S_RD_SHIFT: if (bit_cnt == DATA_LAST) state_nxt = S_DONE;
                S_RD_TURN:  state_nxt = S_RD_SHIFT;
                S_DONE:     state_nxt = S_DONE;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            wr_addr <= '0;
            rd_addr <= '0;
            wr_pend <= 1'b0;
            MISO    <= 1'b0;
        end else begin
            MISO    <= 1'b0;
            wr_pend <= 1'b0;
            bit_cnt <= (state_nxt == state && state != S_IDLE && state != S_DONE)
                       ? bit_cnt + 1'b1 : '0;

            case (state)
                S_CMD, S_WR_ADDR, S_WR_DATA, S_RD_ADDR: shreg <= {shreg[SH_W-2:0], MOSI};
                S_RD_SHIFT: begin
                    // First shift edge takes the word straight from the memory output register
                    if (!abort) begin
                        if (bit_cnt == '0) begin
                            MISO  <= mem_dout[DATA_WIDTH-1];
                            shreg <= SH_W'({mem_dout[DATA_WIDTH-2:0], 1'b0});
                        end else begin
                            MISO  <= shreg[DATA_WIDTH-1];
                            shreg <= SH_W'({shreg[DATA_WIDTH-2:0], 1'b0});
                        end
                    end
                end
                default: ;
            endcase

            if (state == S_WR_ADDR && state_nxt == S_DONE) begin
                wr_addr <= shift_addr;
            end
`ifdef SPI_MEM_AUTO_INC_EN
            else if (wr_pend) begin
                wr_addr <= addr_inc(wr_addr);
            end
            if (state == S_RD_SHIFT && state_nxt == S_DONE) begin
                rd_addr <= addr_inc(rd_addr);
            end
`endif
            if (state == S_RD_ADDR && state_nxt == S_DONE) begin
                rd_addr <= shift_addr;
            end
            if (state == S_WR_DATA && state_nxt == S_DONE) begin
                wr_pend <= 1'b1;
            end
        end
    end

    // Write data stays parked in shreg through DONE until the pending write lands
    spi_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk (clk),
        .we  (wr_pend && rst_n),
        .addr(wr_pend ? wr_addr : rd_addr),
        .din (shreg[DATA_WIDTH-1:0]),
        .dout(mem_dout)
    );

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Randomized frame-level bench for spi_mem_bridge (default depth and depth 200 side by side).
module tb_spi_mem_bridge;
    import spi_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic SS_n = 1'b1;
    logic MOSI = 1'b0;
    logic miso0, miso1;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];

    logic [7:0] mem_m [2][256];
    int         wa [2];
    int         ra [2];
    int         depth [2] = '{256, 200};

    always #5 clk = ~clk;

    spi_mem_bridge dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .SS_n (SS_n),
        .MOSI (MOSI),
        .MISO (miso0)
    );

    spi_mem_bridge #(.MEM_DEPTH(200)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .SS_n (SS_n),
        .MOSI (MOSI),
        .MISO (miso1)
    );

    // Per-cycle MISO check against the expectation pushed for that edge
    initial begin
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (miso0 !== e[0] || miso1 !== e[1]) begin
                    bad++;
                    $display("FAIL miso_cycle t=%0t: got %b%b want %b%b", $time, miso1, miso0, e[1], e[0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    function automatic int inc(input int a, input int d);
        return (a == d - 1) ? 0 : (a + 1) % 256;
    endfunction

    task automatic tick(input logic ss, input logic mosi, input logic rst, input logic e0, input logic e1);
        @(negedge clk);
        SS_n  = ss;
        MOSI  = mosi;
        rst_n = rst;
        exp_q.push_back({e1, e0});
        @(posedge clk);
        #1;
    endtask

    // One frame: edges 0..11 with SS_n low, then DONE hold and SS_n release.
    task automatic frame(input logic [1:0] cmd, input logic [7:0] pl, input int abort_at,
                         input int rst_at, output logic [7:0] obs0, output logic [7:0] obs1);
        logic [7:0] rv [2];
        logic       ss, m, r, e0, e1;
        bit         cut;
        obs0 = '0;
        obs1 = '0;
        cut  = 1'b0;
        for (int i = 0; i < 2; i++)
            rv[i] = (cmd == 2'b11 && ra[i] < depth[i]) ? mem_m[i][ra[i]] : 8'h00;
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 11; k++) begin
            ss = 1'b0;
            r  = 1'b1;
            m  = 1'($urandom_range(0, 1));
            e0 = 1'b0;
            e1 = 1'b0;
            if (k == 1) m = cmd[1];
            if (k == 2) m = cmd[0];
            if (cmd != 2'b11 && k >= 3 && k <= 10) m = pl[10-k];
            if (cmd == 2'b11 && k >= 4) begin
                e0 = rv[0][11-k];
                e1 = rv[1][11-k];
            end
            if (k == abort_at) begin ss = 1'b1; e0 = 1'b0; e1 = 1'b0; cut = 1'b1; end
            if (k == rst_at)   begin ss = 1'b1; r = 1'b0; e0 = 1'b0; e1 = 1'b0; cut = 1'b1; end
            tick(ss, m, r, e0, e1);
            if (cmd == 2'b11 && k >= 4) begin
                obs0 = {obs0[6:0], miso0};
                obs1 = {obs1[6:0], miso1};
            end
            if (cut) break;
        end
        if (!cut) begin
            repeat ($urandom_range(0, 2)) tick(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
            tick(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            if (rst_at >= 0) begin
                wa[i] = 0;
                ra[i] = 0;
            end else if (cmd != 2'b11 ? (abort_at < 0 || abort_at == 11) : (abort_at < 0)) begin
                case (cmd)
                    2'b00: wa[i] = pl;
                    2'b10: ra[i] = pl;
                    2'b01: begin
                        if (wa[i] < depth[i]) mem_m[i][wa[i]] = pl;
`ifdef SPI_MEM_AUTO_INC_EN
                        wa[i] = inc(wa[i], depth[i]);
`endif
                    end
                    default: begin
`ifdef SPI_MEM_AUTO_INC_EN
                        ra[i] = inc(ra[i], depth[i]);
`endif
                    end
                endcase
            end
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] o0, o1;
        frame(2'b00, a, -1, -1, o0, o1);
        frame(2'b01, d, -1, -1, o0, o1);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] o0, output logic [7:0] o1);
        frame(2'b10, a, -1, -1, o0, o1);
        frame(2'b11, 8'h00, -1, -1, o0, o1);
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 6))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'd199;
            3: return 8'd200;
            4: return 8'hFF;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic [7:0] o0, o1;
        int         ab, rs;
        logic [1:0] c;

        wa = '{0, 0};
        ra = '{0, 0};
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_miso", {7'b0, miso0}, 8'h00);
        chk("reset_state", 8'(dut0.state), 8'(S_IDLE));

        for (int a = 0; a < 256; a++) wr(8'(a), 8'($urandom_range(0, 255)));

        wr(8'h10, 8'hA5);
        rd(8'h10, o0, o1);
        chk("rd_a5_d256", o0, 8'hA5);
        chk("rd_a5_d200", o1, 8'hA5);

        wr(8'h20, 8'h69);
        frame(2'b00, 8'h20, -1, -1, o0, o1);
        frame(2'b01, 8'h3C, 6, -1, o0, o1);
        chk("abort_idle0", 8'(dut0.state), 8'(S_IDLE));
        chk("abort_idle1", 8'(dut1.state), 8'(S_IDLE));
        rd(8'h20, o0, o1);
        chk("abort_keep0", o0, 8'h69);
        chk("abort_keep1", o1, 8'h69);

        wr(8'h00, 8'h5E);
        frame(2'b00, 8'hFF, -1, -1, o0, o1);
        frame(2'b01, 8'h11, -1, -1, o0, o1);
        frame(2'b01, 8'h22, -1, -1, o0, o1);
        rd(8'hFF, o0, o1);
`ifdef SPI_MEM_AUTO_INC_EN
        chk("seq_ff_d256", o0, 8'h11);
`else
        chk("seq_ff_d256", o0, 8'h22);
`endif
        chk("seq_ff_d200", o1, 8'h00);
        rd(8'h00, o0, o1);
`ifdef SPI_MEM_AUTO_INC_EN
        chk("seq_00_d256", o0, 8'h22);
        chk("seq_00_d200", o1, 8'h22);
`else
        chk("seq_00_d256", o0, 8'h5E);
        chk("seq_00_d200", o1, 8'h5E);
`endif

        wr(8'hC8, 8'h77);
        rd(8'hC8, o0, o1);
        chk("oor_d256", o0, 8'h77);
        chk("oor_d200", o1, 8'h00);

        wr(8'h00, 8'hC3);
        frame(2'b10, 8'h10, -1, -1, o0, o1);
        frame(2'b11, 8'h00, -1, 6, o0, o1);
        chk("rst_shift_miso", {6'b0, miso1, miso0}, 8'h00);
        frame(2'b11, 8'h00, -1, -1, o0, o1);
        chk("rst_rd0_d256", o0, 8'hC3);
        chk("rst_rd0_d200", o1, 8'hC3);

        for (int n = 0; n < 400; n++) begin
            c  = 2'($urandom_range(0, 3));
            ab = -1;
            rs = -1;
            if ($urandom_range(0, 99) < 10)      ab = $urandom_range(1, 11);
            else if ($urandom_range(0, 99) < 3)  rs = $urandom_range(1, 11);
            frame(c, (c == 2'b01) ? 8'($urandom_range(0, 255)) : pick_addr(), ab, rs, o0, o1);
        end

        repeat (3) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
